// File: rtl/irq_capture4_if.sv
// irq_capture4_if: request, mask and handshake bundle for the irq_capture4 stage.
// slave is the capture block itself; master is the request source / grant consumer.
interface irq_capture4_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic       ovr_clr;
  logic [1:0] code;
  logic       valid;
  logic [3:0] pending;
  logic [3:0] overrun;
  logic       timeout;

  modport slave (
    input  req, mask, ack, ovr_clr,
    output code, valid, pending, overrun, timeout
  );

  modport master (
    output req, mask, ack, ovr_clr,
    input  code, valid, pending, overrun, timeout
  );
endinterface

// File: rtl/irq_capture4.sv
// irq_capture4: four-line interrupt capture with fixed priority (line 3 highest),
// valid/ack grant handshake, ack timeout and per-line overrun flags.
// Build option IRQ_EDGE_DETECT_EN: rising-edge set events plus overrun tracking;
// when undefined, set events are levels and overrun is tied to 0.
module irq_capture4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst,
  irq_capture4_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    code_q, code_nxt;
  logic          valid_q, valid_nxt;
  logic          timeout_q, timeout_nxt;
  logic [3:0]    pending_q, pending_nxt;
  logic [3:0]    overrun_q, overrun_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    set_ev;
  logic [3:0]    pend_mask;
  logic [1:0]    top_idx;

`ifdef IRQ_EDGE_DETECT_EN
  logic [3:0] req_d;

  // Previous request sample; resets to 0 so a line already high counts as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_d <= 4'b0000;
    else     req_d <= bus.req;
  end

  assign set_ev = bus.req & ~req_d;
`else
  logic unused_ovr_clr;

  assign set_ev         = bus.req;
  assign unused_ovr_clr = bus.ovr_clr;
`endif

  assign pend_mask = pending_q & bus.mask;

  // Highest enabled pending line wins.
  always_comb begin
    top_idx = 2'd0;
    if (pend_mask[3])      top_idx = 2'd3;
    else if (pend_mask[2]) top_idx = 2'd2;
    else if (pend_mask[1]) top_idx = 2'd1;
    else                   top_idx = 2'd0;
  end

  // Next-state and next-output logic for the grant FSM, capture and overrun.
  always_comb begin
    state_nxt   = state;
    code_nxt    = code_q;
    valid_nxt   = valid_q;
    timeout_nxt = 1'b0;
    cnt_nxt     = cnt;
    pending_nxt = pending_q | set_ev;
`ifdef IRQ_EDGE_DETECT_EN
    overrun_nxt = (bus.ovr_clr ? 4'b0000 : overrun_q) | (set_ev & pending_q);
`else
    overrun_nxt = 4'b0000;
`endif

    case (state)
      IDLE: begin
        if (|pend_mask) begin
          state_nxt = GRANT;
          code_nxt  = top_idx;
          valid_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          // A fresh event on the granted line in the same cycle keeps it pending.
          if (!set_ev[code_q]) pending_nxt[code_q] = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          state_nxt   = IDLE;
          valid_nxt   = 1'b0;
          timeout_nxt = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = CW'(cnt + 1'b1);
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      code_q    <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt       <= '0;
      pending_q <= 4'b0000;
      overrun_q <= 4'b0000;
    end else begin
      state     <= state_nxt;
      code_q    <= code_nxt;
      valid_q   <= valid_nxt;
      timeout_q <= timeout_nxt;
      cnt       <= cnt_nxt;
      pending_q <= pending_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_capture4.sv
// tb_irq_capture4: directed bench for irq_capture4 with TIMEOUT=4.
module tb_irq_capture4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  irq_capture4_if bus();

  irq_capture4 #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acks every grant on its first valid cycle until nothing is pending.
  task automatic drain();
    int k;
    k = 0;
    while ((bus.pending != 4'b0000 || bus.valid) && k < 40) begin
      bus.ack = bus.valid;
      step();
      k++;
    end
    bus.ack = 1'b0;
    n_cmp++;
    if (k >= 40) begin
      n_bad++;
      $display("FAIL drain_timeout: pending=%b valid=%b not drained in 40 cycles", bus.pending, bus.valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111; bus.mask = 4'b1111; bus.ack = 1'b0; bus.ovr_clr = 1'b0;
    step(); step();
    n_cmp++; if (bus.code !== 2'b00)      begin n_bad++; $display("FAIL rst_code: got %b want 00", bus.code); end
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL rst_pending: got %b want 0000", bus.pending); end
    n_cmp++; if (bus.overrun !== 4'b0000) begin n_bad++; $display("FAIL rst_overrun: got %b want 0000", bus.overrun); end
    n_cmp++; if (bus.timeout !== 1'b0)    begin n_bad++; $display("FAIL rst_timeout: got %b want 0", bus.timeout); end
    rst = 1'b0;
    step();
    n_cmp++; if (bus.pending !== 4'b1111) begin n_bad++; $display("FAIL rel_pending: got %b want 1111", bus.pending); end
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL rel_valid0: got %b want 0", bus.valid); end
    bus.req = 4'b0000;
    step();
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL rel_valid1: got %b want 1", bus.valid); end
    n_cmp++; if (bus.code !== 2'b11)      begin n_bad++; $display("FAIL rel_code: got %b want 11", bus.code); end
    drain();
  endtask

  task automatic test_priority();
    bus.mask = 4'b1111;
    bus.req = 4'b0110;
    step();
    bus.req = 4'b0000;
    n_cmp++; if (bus.pending !== 4'b0110) begin n_bad++; $display("FAIL prio_pending: got %b want 0110", bus.pending); end
    step();
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL prio_valid_a: got %b want 1", bus.valid); end
    n_cmp++; if (bus.code !== 2'b10)      begin n_bad++; $display("FAIL prio_code_a: got %b want 10", bus.code); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL prio_gap: got %b want 0", bus.valid); end
    n_cmp++; if (bus.pending !== 4'b0010) begin n_bad++; $display("FAIL prio_pending_mid: got %b want 0010", bus.pending); end
    step();
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL prio_valid_b: got %b want 1", bus.valid); end
    n_cmp++; if (bus.code !== 2'b01)      begin n_bad++; $display("FAIL prio_code_b: got %b want 01", bus.code); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL prio_pending_end: got %b want 0000", bus.pending); end
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL prio_valid_end: got %b want 0", bus.valid); end
  endtask

  task automatic test_mask_no_preempt();
    bus.mask = 4'b0011;
    bus.req = 4'b1001;
    step();
    bus.req = 4'b0000;
    step();
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL mask_valid: got %b want 1", bus.valid); end
    n_cmp++; if (bus.code !== 2'b00)      begin n_bad++; $display("FAIL mask_code: got %b want 00", bus.code); end
    bus.mask = 4'b1111;
    step();
    n_cmp++; if (bus.code !== 2'b00)      begin n_bad++; $display("FAIL nopre_code1: got %b want 00", bus.code); end
    step();
    n_cmp++; if (bus.code !== 2'b00)      begin n_bad++; $display("FAIL nopre_code2: got %b want 00", bus.code); end
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL nopre_valid: got %b want 1", bus.valid); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (bus.pending !== 4'b1000) begin n_bad++; $display("FAIL nopre_pending: got %b want 1000", bus.pending); end
    step();
    n_cmp++; if (bus.code !== 2'b11)      begin n_bad++; $display("FAIL nopre_next_code: got %b want 11", bus.code); end
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL nopre_next_valid: got %b want 1", bus.valid); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
  endtask

  task automatic test_timeout();
    bus.mask = 4'b0000;
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (bus.pending !== 4'b0100) begin n_bad++; $display("FAIL idle_ack_pending: got %b want 0100", bus.pending); end
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL masked_valid: got %b want 0", bus.valid); end
    bus.mask = 4'b0100;
    step();
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL to_valid_start: got %b want 1", bus.valid); end
    n_cmp++; if (bus.code !== 2'b10)      begin n_bad++; $display("FAIL to_code: got %b want 10", bus.code); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.valid !== 1'b1 || bus.timeout !== 1'b0) begin
        n_bad++; $display("FAIL to_hold_%0d: valid=%b timeout=%b want valid=1 timeout=0", i, bus.valid, bus.timeout);
      end
    end
    step();
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL to_valid_drop: got %b want 0", bus.valid); end
    n_cmp++; if (bus.timeout !== 1'b1)    begin n_bad++; $display("FAIL to_pulse: got %b want 1", bus.timeout); end
    n_cmp++; if (bus.pending !== 4'b0100) begin n_bad++; $display("FAIL to_pending: got %b want 0100", bus.pending); end
    step();
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL to_regrant: got %b want 1", bus.valid); end
    n_cmp++; if (bus.timeout !== 1'b0)    begin n_bad++; $display("FAIL to_pulse_end: got %b want 0", bus.timeout); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL to_clear: got %b want 0000", bus.pending); end
  endtask

  task automatic test_overrun();
    logic [3:0] exp_ovr;
`ifdef IRQ_EDGE_DETECT_EN
    exp_ovr = 4'b0010;
`else
    exp_ovr = 4'b0000;
`endif
    bus.mask = 4'b0010;
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    n_cmp++; if (bus.code !== 2'b01 || bus.valid !== 1'b1) begin
      n_bad++; $display("FAIL ovr_grant: code=%b valid=%b want code=01 valid=1", bus.code, bus.valid);
    end
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    n_cmp++; if (bus.overrun !== exp_ovr) begin n_bad++; $display("FAIL ovr_set: got %b want %b", bus.overrun, exp_ovr); end
    step();
    bus.req = 4'b0010;
    bus.ack = 1'b1;
    step();
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL ovr_ack_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.pending !== 4'b0010) begin n_bad++; $display("FAIL ovr_ack_pending: got %b want 0010", bus.pending); end
    n_cmp++; if (bus.overrun !== exp_ovr) begin n_bad++; $display("FAIL ovr_sticky: got %b want %b", bus.overrun, exp_ovr); end
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    n_cmp++; if (bus.overrun !== 4'b0000) begin n_bad++; $display("FAIL ovr_clr: got %b want 0000", bus.overrun); end
    n_cmp++; if (bus.valid !== 1'b1)      begin n_bad++; $display("FAIL ovr_regrant: got %b want 1", bus.valid); end
    bus.ack = 1'b1;
    step();
    bus.ack = 1'b0;
    n_cmp++; if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL ovr_pending_end: got %b want 0000", bus.pending); end
  endtask

  task automatic test_reset_mid_grant();
    bus.mask = 4'b1000;
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0000;
    step();
    n_cmp++; if (bus.valid !== 1'b1 || bus.code !== 2'b11) begin
      n_bad++; $display("FAIL mid_pre: valid=%b code=%b want valid=1 code=11", bus.valid, bus.code);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.valid !== 1'b0)      begin n_bad++; $display("FAIL mid_valid: got %b want 0", bus.valid); end
    n_cmp++; if (bus.code !== 2'b00)      begin n_bad++; $display("FAIL mid_code: got %b want 00", bus.code); end
    n_cmp++; if (bus.pending !== 4'b0000) begin n_bad++; $display("FAIL mid_pending: got %b want 0000", bus.pending); end
    #2;
    rst = 1'b0;
    step();
    n_cmp++; if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
      n_bad++; $display("FAIL mid_after: valid=%b pending=%b want valid=0 pending=0000", bus.valid, bus.pending);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask_no_preempt();
    test_timeout();
    test_overrun();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_capture4.md
# irq_capture4

Four-line interrupt request capture and arbitration stage that sits directly upstream of the 4-to-2 priority encoding in the request path. It latches incoming request events into a pending register and, among enabled pending lines, presents the highest-priority line as a 2-bit code. Line 3 is highest priority and line 0 is lowest. The code is held stable under a valid/ack handshake, and the pending bit is cleared when the consumer acknowledges. The block also supplies an ack timeout and per-line overrun flags.

## Interface
- `TIMEOUT`, default 16: number of cycles `valid` may stay high without `ack` before the grant is withdrawn; 0 disables the timeout.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  raw request lines, sampled synchronously on `clk`.
- `mask`  in  4  per-line enable (1 = line may be granted); does not gate capture into `pending`.
- `ack`  in  1  consumer acknowledge; only meaningful while `valid`=1.
- `ovr_clr`  in  1  clears all `overrun` flags.
- `code`  out  2  granted line index; 3→2'b11, 2→2'b10, 1→2'b01, 0→2'b00.
- `valid`  out  1  `code` is presented and held.
- `pending`  out  4  captured, not-yet-serviced requests.
- `overrun`  out  4  sticky: a new event arrived on a line already pending.
- `timeout`  out  1  one-cycle pulse when a grant is withdrawn for lack of `ack`.

## Operation
- Reset values:
  - `code`=0, `valid`=0, `pending`=0, `overrun`=0, `timeout`=0.
  - Internal `req_d`=0, FSM in IDLE, timeout counter=0.
- **Set event** on line i:
  - Edge mode (see Configuration): `req[i] & ~req_d[i]`.
  - Level mode: `req[i]`.
- **Capture:** `pending[i]` is set on every set event. This happens in any FSM state and independently of `mask`.
- **Overrun:**
  - `overrun[i]` is set when a set event occurs while `pending[i]` is already 1.
  - `ovr_clr` clears all overrun bits.
  - If a clear and a set for the same bit fall in the same cycle, set wins.
- **FSM states:** IDLE, GRANT.
  - IDLE → GRANT when `pending & mask` ≠ 0. `code` is loaded with the highest set index of `pending & mask`, `valid` goes to 1, and the counter is cleared.
  - GRANT + `ack` → IDLE. `valid` goes to 0 and `pending[code]` is cleared. If a set event on that same line occurs in the same cycle, the bit stays 1 and `overrun` is set.
  - GRANT, no `ack`, `TIMEOUT`≠0, counter = `TIMEOUT`-1 → IDLE. `valid` goes to 0, `timeout` pulses for 1 cycle, `pending` is unchanged, and the line is re-arbitrated later.
  - GRANT otherwise: the counter increments.
- **No preemption:**
  - While in GRANT, `code` is frozen.
  - A higher-priority arrival or a `mask` change does not alter it.
  - The grant completes only by `ack` or timeout.
- **Outside GRANT:** `ack` while `valid`=0 is ignored.
- **Counter width:** $clog2(TIMEOUT+1) bits; it saturates and never wraps.

## Timing
- Request-to-pending latency: `req` sampled at edge n → `pending` visible after edge n (1 cycle).
- Pending-to-valid latency: 1 cycle.
  - IDLE with `pending & mask` ≠ 0 after edge n → `valid`=1 after edge n+1.
  - A raw `req` edge therefore yields `valid` 2 cycles later.
- Ack: `ack`=1 sampled at edge m → `valid`=0 and the pending bit cleared after edge m.
- Back-to-back grants: there is always at least one cycle with `valid`=0 between grants.
- Timeout: with no `ack`, `valid` is high for exactly `TIMEOUT` cycles, then `timeout`=1 for 1 cycle coincident with `valid`=0.
- Reset mid-grant: `valid` and `code` drop immediately (asynchronous), and all pending requests are lost.
- First cycle after reset in edge mode: a `req` line already high counts as an edge, because `req_d` resets to 0.

## Configuration
- Macro: `IRQ_EDGE_DETECT_EN`.
- Defined:
  - The `req_d` register is present.
  - Set events are rising edges.
  - `overrun` operates as described in Operation.
- Undefined:
  - Set events are levels and `req_d` is removed.
  - `overrun` is tied to 0 and `ovr_clr` is ignored, because a sustained level would flag continuously.

## Test plan
1. Reset: `rst`=1 with `req`=4'b1111 → all outputs 0. Release with edge mode → `pending`=4'b1111 after 1 cycle, `valid`=1 with `code`=2'b11 after 2 cycles.
2. Priority: `mask`=4'b1111, pulse `req`=4'b0110 for one cycle, ack each grant on its first valid cycle → `code`=2'b10 then `code`=2'b01, separated by one `valid`=0 cycle. `pending` ends at 0.
3. Mask and no preemption: `mask`=4'b0011, pending 4'b1001 → `code`=2'b00. Set `mask`=4'b1111 during the grant → `code` stays 2'b00 until `ack`, then the next grant is `code`=2'b11.
4. Timeout: `TIMEOUT`=4, pending 4'b0100, never ack → `valid` high for 4 cycles, `timeout` pulses once, `pending` still 4'b0100, and `valid` reasserts 1 cycle later.
5. Overrun (edge mode): pulse `req[1]` twice before ack → `overrun`=4'b0010. `ack` coincident with a new `req[1]` edge → `pending[1]` stays 1. `ovr_clr` → `overrun`=0.
6. Reset mid-grant: assert `rst` asynchronously between clock edges while `valid`=1 → `valid`, `code` and `pending` go to 0 before the next edge.
